mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Parametrised successor to the single-cycle memory stage of the RV32 pipeline. Sits between Execute (E) and Writeback (W).
- Adds byte, halfword and word loads/stores with sign/zero extension (funct3).
- Adds a configurable multi-cycle data-memory latency with a pipeline stall handshake, and misalignment detection.
- Provides the E->W pipeline register and the E->F redirect pass-through.

Parameters:
- DEPTH, 256, data memory depth in 32-bit words (power of 2).
- MEM_LATENCY, 1, cycles a load/store occupies the stage (>=1). 1 = no stall.
- SEL_WIDTH, 6, width of the ALUSelect pass-through.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ALUOutE  in  32  effective address / ALU result
- StoreDataE  in  32  store data, taken from low bits for sb/sh
- Funct3E  in  3  load/store size and sign
- MemWriteE, MemReadE, RegWriteE, JtypeE, BranchE  in  1 each  control
- WriteAddressE  in  5  rd
- ALUSelectE  in  SEL_WIDTH  pass-through to W
- PCPlusImmE  in  32  branch/jump target
- StallM  out  1  combinational; upstream must hold all E inputs stable while high
- MisalignM  out  1  combinational misaligned-access flag
- ALUOutF, PCPlusImmF  out  32  combinational pass-through of E inputs
- JtypeF, BranchF  out  1  JtypeE & ~StallM, BranchE & ~StallM
- DataMemOutW, ALUOutW  out  32  registered
- RegWriteW, MemReadW, JtypeW  out  1  registered
- WriteAddressW  out  5  registered
- ALUSelectW  out  SEL_WIDTH  registered

Behaviour:
- Reset (reset=0, asynchronous):
  - All W outputs are 0. FSM goes to IDLE and the counter to 0.
  - Memory contents are not reset. Reset mid-access abandons the access; a pending store is never committed.
- Memory addressing:
  - Word index = ALUOutE[log2(DEPTH)+1:2]. Addresses wrap modulo DEPTH; there is no range error.
- Access definition: access = (MemReadE | MemWriteE) & ~MisalignM. If both MemReadE and MemWriteE are set, the write wins and the cycle is treated as a store (MemReadW=0).
- Misalignment:
  - MisalignM=1 when the access is halfword with ALUOutE[0]=1, or word with ALUOutE[1:0]!=0.
  - A misaligned access performs no memory write, raises no stall, and drives DataMemOutW=0 and RegWriteW=0 on its W cycle.
- Funct3 encoding:
  - 000 = byte signed; 001 = half signed; 010 = word; 100 = byte unsigned; 101 = half unsigned.
  - 011, 110 and 111 are treated as word.
- Stores:
  - Byte store writes lane ALUOutE[1:0] with StoreDataE[7:0].
  - Half store writes lanes {ALUOutE[1],0} and {ALUOutE[1],1} with StoreDataE[15:0].
  - Word store writes all four lanes.
  - Other lanes are untouched. The write commits exactly once, on the final cycle of the access.
- Loads: the selected lane(s) are right-aligned, then sign- or zero-extended per funct3.
- FSM (states IDLE, BUSY):
  - IDLE with access and MEM_LATENCY>1: StallM=1, counter loads MEM_LATENCY-2, go to BUSY.
  - BUSY with counter>0: StallM=1, counter decrements.
  - BUSY with counter==0: StallM=0; this is the final cycle; go to IDLE.
  - With MEM_LATENCY==1, every access completes in IDLE with StallM=0.
  - Non-memory instructions never stall.
- W register: on each rising edge (reset high):
  - If StallM=1, load a bubble: RegWriteW=0, MemReadW=0, JtypeW=0; other W fields keep their old values.
  - Otherwise capture the E inputs, and DataMemOutW = the extended load data (0 for stores and non-memory instructions).
- Latency: an access presented at cycle T is visible at W after edge T+MEM_LATENCY. Non-memory instructions are visible after edge T+1.
- Back-to-back accesses: a new access may be presented in the cycle after the final cycle; no idle gap is required.

Test Plan:
- MEM_LATENCY=1. Store word 0xDEADBEEF at address 0x10, then load word from 0x10 (Funct3=010) -> DataMemOutW=0xDEADBEEF one edge later. StallM stays 0 throughout.
- Store byte 0x80 to 0x21, then load signed byte (000) from 0x21 -> 0xFFFFFF80. Load unsigned byte (100) -> 0x00000080. Load word from 0x20 -> 0x00008000, given the word was prior-zeroed.
- MEM_LATENCY=3. Load word issued at T -> StallM=1 during T and T+1, 0 at T+2. RegWriteW=0 after edges T+1 and T+2. Data with RegWriteW=1 after edge T+3.
- Load half from 0x13 -> MisalignM=1, no stall, RegWriteW=0, DataMemOutW=0. Store word to 0x0E -> memory unchanged on readback.
- Address wrap with DEPTH=256: store 0x12345678 at 0xFFFFFFFC, then load from 0x3FC -> 0x12345678.
- MEM_LATENCY=3. Assert reset=0 in the second stalled cycle of a store -> all W outputs 0 immediately. After release, FSM is IDLE and readback shows the store did not commit. Also check BranchF=0 while StallM=1.

Source files
------------

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: RV32 memory stage between Execute and Writeback.
// Byte/half/word loads and stores with sign/zero extension, a configurable
// multi-cycle memory latency with a stall handshake, misalignment detection,
// the E->W pipeline register and the E->F redirect pass-through.
//
// Ports:
//   clk, reset (async, active low)
//   E inputs : ALUOutE, StoreDataE, Funct3E, MemWriteE, MemReadE, RegWriteE,
//              JtypeE, BranchE, WriteAddressE, ALUSelectE, PCPlusImmE
//   M outputs: StallM, MisalignM (combinational)
//   F outputs: ALUOutF, PCPlusImmF, JtypeF, BranchF (combinational)
//   W outputs: DataMemOutW, ALUOutW, RegWriteW, MemReadW, JtypeW,
//              WriteAddressW, ALUSelectW (registered)
module mem_stage_mc #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned SEL_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          ALUOutE,
    input  logic [31:0]          StoreDataE,
    input  logic [2:0]           Funct3E,
    input  logic                 MemWriteE,
    input  logic                 MemReadE,
    input  logic                 RegWriteE,
    input  logic                 JtypeE,
    input  logic                 BranchE,
    input  logic [4:0]           WriteAddressE,
    input  logic [SEL_WIDTH-1:0] ALUSelectE,
    input  logic [31:0]          PCPlusImmE,
    output logic                 StallM,
    output logic                 MisalignM,
    output logic [31:0]          ALUOutF,
    output logic [31:0]          PCPlusImmF,
    output logic                 JtypeF,
    output logic                 BranchF,
    output logic [31:0]          DataMemOutW,
    output logic [31:0]          ALUOutW,
    output logic                 RegWriteW,
    output logic                 MemReadW,
    output logic                 JtypeW,
    output logic [4:0]           WriteAddressW,
    output logic [SEL_WIDTH-1:0] ALUSelectW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [CW-1:0] CntLoad = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
    localparam bit MultiCycle = (MEM_LATENCY > 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          stateQ, stateD;
    logic [CW-1:0]   cntQ, cntD;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wordIdx;
    logic            isByte, isHalf, isWord, isUnsigned;
    logic            memOp, access, isLoad, commit;
    logic [3:0]      byteEn;
    logic [31:0]     wrData, rdWord, rdShift, loadData;

    // Address wraps modulo DEPTH: upper address bits are simply ignored.
    assign wordIdx = ALUOutE[AW+1:2];

    // Funct3 low bits pick the size; 011/110/111 fall through to word.
    assign isByte     = (Funct3E[1:0] == 2'b00);
    assign isHalf     = (Funct3E[1:0] == 2'b01);
    assign isWord     = ~isByte & ~isHalf;
    assign isUnsigned = Funct3E[2];

    assign memOp     = MemReadE | MemWriteE;
    assign MisalignM = memOp & ((isHalf & ALUOutE[0]) | (isWord & (|ALUOutE[1:0])));
    assign access    = memOp & ~MisalignM;
    assign isLoad    = MemReadE & ~MemWriteE;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        StallM = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (access && MultiCycle) begin
                    StallM = 1'b1;
                    cntD   = CntLoad;
                    stateD = StBusy;
                end
            end
            StBusy: begin
                if (cntQ != '0) begin
                    StallM = 1'b1;
                    cntD   = cntQ - CW'(1);
                end else begin
                    stateD = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Store lane steering: replicate the data so each lane sees its byte.
    always_comb begin
        byteEn = 4'hF;
        wrData = StoreDataE;
        if (isByte) begin
            byteEn = 4'b0001 << ALUOutE[1:0];
            wrData = {4{StoreDataE[7:0]}};
        end else if (isHalf) begin
            byteEn = ALUOutE[1] ? 4'b1100 : 4'b0011;
            wrData = {2{StoreDataE[15:0]}};
        end
    end

    // Commit only on the final (non-stalled) cycle; gating with reset keeps
    // an access abandoned by reset from ever reaching the array.
    assign commit = access & MemWriteE & ~StallM & reset;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    assign rdWord  = mem[wordIdx];
    assign rdShift = rdWord >> {ALUOutE[1:0], 3'b000};

    always_comb begin
        loadData = rdWord;
        if (isByte) begin
            loadData = {{24{~isUnsigned & rdShift[7]}}, rdShift[7:0]};
        end else if (isHalf) begin
            loadData = {{16{~isUnsigned & rdShift[15]}}, rdShift[15:0]};
        end
    end

    assign ALUOutF    = ALUOutE;
    assign PCPlusImmF = PCPlusImmE;
    assign JtypeF     = JtypeE & ~StallM;
    assign BranchF    = BranchE & ~StallM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DataMemOutW   <= '0;
            ALUOutW       <= '0;
            RegWriteW     <= 1'b0;
            MemReadW      <= 1'b0;
            JtypeW        <= 1'b0;
            WriteAddressW <= '0;
            ALUSelectW    <= '0;
        end else if (StallM) begin
            // Bubble: kill the side-effecting controls, leave data fields alone.
            RegWriteW <= 1'b0;
            MemReadW  <= 1'b0;
            JtypeW    <= 1'b0;
        end else begin
            DataMemOutW   <= (access && isLoad) ? loadData : '0;
            ALUOutW       <= ALUOutE;
            RegWriteW     <= RegWriteE & ~MisalignM;
            MemReadW      <= isLoad;
            JtypeW        <= JtypeE;
            WriteAddressW <= WriteAddressE;
            ALUSelectW    <= ALUSelectE;
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [2:0]  f3;
        logic        we;
        logic        re;
        logic        rw;
        logic        j;
        logic        br;
        logic [4:0]  wa;
        logic [5:0]  sel;
        logic [31:0] pc;
    } eIn_t;

    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        jtype;
        logic [4:0]  wa;
        logic [5:0]  sel;
        logic [31:0] alu;
        logic [31:0] data;
    } wExp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    eIn_t inA = '0;
    eIn_t inB = '0;

    logic        stallA, misA, jfA, bfA, rwA, mrA, jwA;
    logic        stallB, misB, jfB, bfB, rwB, mrB, jwB;
    logic [31:0] aluFA, pcFA, dataA, aluWA;
    logic [31:0] aluFB, pcFB, dataB, aluWB;
    logic [4:0]  waA, waB;
    logic [5:0]  selA, selB;

    wExp_t sbA[$];
    wExp_t sbB[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_mc #(.DEPTH(256), .MEM_LATENCY(1), .SEL_WIDTH(6)) dutA (
        .clk(clk), .reset(reset),
        .ALUOutE(inA.addr), .StoreDataE(inA.sdata), .Funct3E(inA.f3),
        .MemWriteE(inA.we), .MemReadE(inA.re), .RegWriteE(inA.rw),
        .JtypeE(inA.j), .BranchE(inA.br), .WriteAddressE(inA.wa),
        .ALUSelectE(inA.sel), .PCPlusImmE(inA.pc),
        .StallM(stallA), .MisalignM(misA), .ALUOutF(aluFA), .PCPlusImmF(pcFA),
        .JtypeF(jfA), .BranchF(bfA), .DataMemOutW(dataA), .ALUOutW(aluWA),
        .RegWriteW(rwA), .MemReadW(mrA), .JtypeW(jwA), .WriteAddressW(waA),
        .ALUSelectW(selA)
    );

    mem_stage_mc #(.DEPTH(256), .MEM_LATENCY(3), .SEL_WIDTH(6)) dutB (
        .clk(clk), .reset(reset),
        .ALUOutE(inB.addr), .StoreDataE(inB.sdata), .Funct3E(inB.f3),
        .MemWriteE(inB.we), .MemReadE(inB.re), .RegWriteE(inB.rw),
        .JtypeE(inB.j), .BranchE(inB.br), .WriteAddressE(inB.wa),
        .ALUSelectE(inB.sel), .PCPlusImmE(inB.pc),
        .StallM(stallB), .MisalignM(misB), .ALUOutF(aluFB), .PCPlusImmF(pcFB),
        .JtypeF(jfB), .BranchF(bfB), .DataMemOutW(dataB), .ALUOutW(aluWB),
        .RegWriteW(rwB), .MemReadW(mrB), .JtypeW(jwB), .WriteAddressW(waB),
        .ALUSelectW(selB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic eIn_t mk(input logic we, input logic re, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [4:0] wa);
        eIn_t e;
        e       = '0;
        e.we    = we;
        e.re    = re;
        e.rw    = re & ~we;
        e.f3    = f3;
        e.addr  = addr;
        e.sdata = sdata;
        e.wa    = wa;
        e.sel   = 6'(wa) + 6'd1;
        e.pc    = addr + 32'd4;
        return e;
    endfunction

    // Drive one instruction, wait for its W capture, compare with the scoreboard.
    task automatic runOp(input bit useB, input eIn_t e, input logic [31:0] expData,
                         input bit expMis, input int expStalls, input string tag);
        wExp_t x;
        int    stalls;
        bit    done;
        logic  st;
        x.regWrite = e.rw & ~expMis;
        x.memRead  = e.re & ~e.we;
        x.jtype    = e.j;
        x.wa       = e.wa;
        x.sel      = e.sel;
        x.alu      = e.addr;
        x.data     = expData;
        if (useB) begin
            sbB.push_back(x);
            inB = e;
        end else begin
            sbA.push_back(x);
            inA = e;
        end
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            st = useB ? stallB : stallA;
            if (c == 0) begin
                check({tag, " misalign"}, 32'(useB ? misB : misA), 32'(expMis));
                check({tag, " JtypeF"}, 32'(useB ? jfB : jfA), 32'(e.j & (expStalls == 0)));
                check({tag, " ALUOutF"}, useB ? aluFB : aluFA, e.addr);
                check({tag, " PCPlusImmF"}, useB ? pcFB : pcFA, e.pc);
            end
            @(posedge clk);
            #1;
            if (st) begin
                stalls++;
                check({tag, " bubble RegWriteW"}, 32'(useB ? rwB : rwA), 32'd0);
                check({tag, " bubble MemReadW"}, 32'(useB ? mrB : mrA), 32'd0);
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s timeout: observed stalled expected completion", tag);
        end
        check({tag, " stall cycles"}, 32'(stalls), 32'(expStalls));
        if (done) begin
            x = useB ? sbB.pop_front() : sbA.pop_front();
            check({tag, " DataMemOutW"}, useB ? dataB : dataA, x.data);
            check({tag, " ALUOutW"}, useB ? aluWB : aluWA, x.alu);
            check({tag, " ctrlW"},
                  useB ? {20'd0, rwB, mrB, jwB, waB, selB} : {20'd0, rwA, mrA, jwA, waA, selA},
                  {20'd0, x.regWrite, x.memRead, x.jtype, x.wa, x.sel});
        end
        if (useB) inB = '0;
        else inA = '0;
    endtask

    initial begin
        eIn_t e;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst A DataMemOutW", dataA, 32'd0);
        check("rst A ALUOutW", aluWA, 32'd0);
        check("rst A ctrl", {24'd0, rwA, mrA, jwA, waA}, 32'd0);
        check("rst B DataMemOutW", dataB, 32'd0);
        check("rst B ctrl", {18'd0, rwB, mrB, jwB, waB, selB}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // MEM_LATENCY = 1
        runOp(0, mk(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1), 32'd0, 0, 0, "sw 0x10");
        runOp(0, mk(0, 1, 3'b010, 32'h10, 32'd0, 5'd2), 32'hDEADBEEF, 0, 0, "lw 0x10");
        runOp(0, mk(1, 0, 3'b010, 32'h20, 32'd0, 5'd3), 32'd0, 0, 0, "sw 0x20 zero");
        runOp(0, mk(1, 0, 3'b000, 32'h21, 32'hABCDEF80, 5'd4), 32'd0, 0, 0, "sb 0x21");
        runOp(0, mk(0, 1, 3'b000, 32'h21, 32'd0, 5'd5), 32'hFFFFFF80, 0, 0, "lb 0x21");
        runOp(0, mk(0, 1, 3'b100, 32'h21, 32'd0, 5'd6), 32'h00000080, 0, 0, "lbu 0x21");
        runOp(0, mk(0, 1, 3'b010, 32'h20, 32'd0, 5'd7), 32'h00008000, 0, 0, "lw 0x20");
        runOp(0, mk(1, 0, 3'b001, 32'h22, 32'h1234A5A5, 5'd8), 32'd0, 0, 0, "sh 0x22");
        runOp(0, mk(0, 1, 3'b001, 32'h22, 32'd0, 5'd9), 32'hFFFFA5A5, 0, 0, "lh 0x22");
        runOp(0, mk(0, 1, 3'b101, 32'h22, 32'd0, 5'd10), 32'h0000A5A5, 0, 0, "lhu 0x22");
        runOp(0, mk(0, 1, 3'b011, 32'h20, 32'd0, 5'd11), 32'hA5A58000, 0, 0, "lw(011) 0x20");
        runOp(0, mk(0, 1, 3'b001, 32'h13, 32'd0, 5'd12), 32'd0, 1, 0, "lh misaligned 0x13");
        runOp(0, mk(1, 0, 3'b010, 32'h0C, 32'h13572468, 5'd13), 32'd0, 0, 0, "sw 0x0C");
        runOp(0, mk(1, 0, 3'b010, 32'h0E, 32'h55555555, 5'd14), 32'd0, 1, 0, "sw misaligned 0x0E");
        runOp(0, mk(0, 1, 3'b010, 32'h0C, 32'd0, 5'd15), 32'h13572468, 0, 0, "lw 0x0C");
        runOp(0, mk(1, 0, 3'b010, 32'hFFFFFFFC, 32'h12345678, 5'd16), 32'd0, 0, 0, "sw wrap");
        runOp(0, mk(0, 1, 3'b010, 32'h3FC, 32'd0, 5'd17), 32'h12345678, 0, 0, "lw 0x3FC");
        e = '0; e.rw = 1'b1; e.j = 1'b1; e.addr = 32'h777; e.wa = 5'd7; e.sel = 6'h2A;
        e.pc = 32'h1000;
        runOp(0, e, 32'd0, 0, 0, "A alu op");

        // MEM_LATENCY = 3
        runOp(1, mk(1, 0, 3'b010, 32'h50, 32'hA1B2C3D4, 5'd1), 32'd0, 0, 2, "B sw 0x50");
        runOp(1, mk(0, 1, 3'b010, 32'h50, 32'd0, 5'd2), 32'hA1B2C3D4, 0, 2, "B lw 0x50");
        runOp(1, mk(0, 1, 3'b000, 32'h53, 32'd0, 5'd3), 32'hFFFFFFA1, 0, 2, "B lb 0x53");
        runOp(1, mk(0, 1, 3'b010, 32'h52, 32'd0, 5'd4), 32'd0, 1, 0, "B lw misaligned");
        runOp(1, e, 32'd0, 0, 0, "B alu op");
        runOp(1, mk(1, 0, 3'b010, 32'h40, 32'h11111111, 5'd5), 32'd0, 0, 2, "B sw 0x40");
        runOp(1, mk(0, 1, 3'b010, 32'h40, 32'd0, 5'd6), 32'h11111111, 0, 2, "B lw 0x40");

        // Reset in the second stalled cycle of a store
        e = mk(1, 0, 3'b010, 32'h40, 32'hCAFEF00D, 5'd9);
        e.br = 1'b1;
        inB = e;
        @(negedge clk);
        check("B store stall 1", 32'(stallB), 32'd1);
        check("B BranchF stalled 1", 32'(bfB), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("B store stall 2", 32'(stallB), 32'd1);
        check("B BranchF stalled 2", 32'(bfB), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("B mid rst DataMemOutW", dataB, 32'd0);
        check("B mid rst ALUOutW", aluWB, 32'd0);
        check("B mid rst ctrl", {18'd0, rwB, mrB, jwB, waB, selB}, 32'd0);
        inB = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("B idle after rst", 32'(stallB), 32'd0);
        @(posedge clk);
        #1;
        runOp(1, mk(0, 1, 3'b010, 32'h40, 32'd0, 5'd10), 32'h11111111, 0, 2, "B lw after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
